// File: rtl/checker_pkg.sv
// checker_pkg
// Shared types and constants for the vector response checker.
//   state_t       : run-control states (IDLE, RUN, DONE)
//   DEFAULT_TABLE : expected out per {A,B,C,D}; encodes (A&B)|(C&D)
//   vecIndex()    : packs the four stimulus bits into a table index, A as MSB
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEFAULT_TABLE = 16'hF888;

  function automatic logic [3:0] vecIndex(input logic a, input logic b,
                                          input logic c, input logic d);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, count -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : advance by one unless already saturated
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Clear takes priority so a restart always begins from zero, even if an
  // increment request arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/vector_response_checker.sv
// vector_response_checker
// Compares a DUT's 1-bit response against a 16-entry truth table for each
// strobed {A,B,C,D} vector, tallies passes/fails and records the first miss.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : one-cycle pulse, clears results and begins a run
//   vec_valid         : A/B/C/D/out_dut valid this cycle
//   A, B, C, D        : stimulus bits 3..0
//   out_dut           : DUT response for the current vector
//   busy / done       : run in progress / run complete
//   all_pass          : done with zero failures
//   pass_count        : matching vectors this run (saturating)
//   fail_count        : mismatching vectors this run (saturating)
//   first_fail_valid  : a mismatch has been captured this run
//   first_fail_vec    : {A,B,C,D} of the first mismatch
//   first_fail_got    : out_dut value at the first mismatch
module vector_response_checker
  import checker_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = DEFAULT_TABLE,
  parameter int          NUM_VECTORS = 4,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             out_dut,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_got
);

  // Vector counter is 8 bits wide so it can always reach NUM_VECTORS (<=255)
  // regardless of how narrow the saturating result counters are.
  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_vecCount;
  logic       r_ffValid;
  logic [3:0] r_ffVec;
  logic       r_ffGot;

  logic       w_clear;
  logic       w_accept;
  logic [3:0] w_index;
  logic       w_expected;
  logic       w_match;
  logic [CNT_W-1:0] w_passCount;
  logic [CNT_W-1:0] w_failCount;

  assign w_index    = vecIndex(A, B, C, D);
  assign w_expected = TRUTH_TABLE[w_index];
  assign w_match    = (out_dut == w_expected);

  // Next-state logic. start is honoured in every state and always beats a
  // coincident vec_valid; vectors are only scored while a run is active.
  always_comb begin
    w_nextState = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = RUN;
          w_clear     = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          w_clear = 1'b1;
        end else if (vec_valid) begin
          w_accept = 1'b1;
          if (r_vecCount == LAST_IDX) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          w_nextState = RUN;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Run-length counter; only used to decide when the run is complete, so it
  // never needs to saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vecCount <= '0;
    end else if (w_clear) begin
      r_vecCount <= '0;
    end else if (w_accept) begin
      r_vecCount <= r_vecCount + 1'b1;
    end
  end

  // First-failure capture: latches once per run and then holds until the
  // next start, so later mismatches cannot overwrite the original evidence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ffValid <= 1'b0;
      r_ffVec   <= '0;
      r_ffGot   <= 1'b0;
    end else if (w_clear) begin
      r_ffValid <= 1'b0;
      r_ffVec   <= '0;
      r_ffGot   <= 1'b0;
    end else if (w_accept && !w_match && !r_ffValid) begin
      r_ffValid <= 1'b1;
      r_ffVec   <= w_index;
      r_ffGot   <= out_dut;
    end
  end

  sat_counter #(.W(CNT_W)) u_passCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clear),
    .inc   (w_accept && w_match),
    .count (w_passCount)
  );

  sat_counter #(.W(CNT_W)) u_failCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clear),
    .inc   (w_accept && !w_match),
    .count (w_failCount)
  );

  assign busy             = (r_state == RUN);
  assign done             = (r_state == DONE);
  assign all_pass         = (r_state == DONE) && (w_failCount == '0);
  assign pass_count       = w_passCount;
  assign fail_count       = w_failCount;
  assign first_fail_valid = r_ffValid;
  assign first_fail_vec   = r_ffVec;
  assign first_fail_got   = r_ffGot;

endmodule
